regfile_sb: RTL and testbench

Parametrised successor to the 16-entry MIPS register file, used in the decode stage of the pipelined core. It provides two combinational read ports and one synchronous write port over a configurable-width, configurable-depth array, with optional hardwired-zero register 0. A per-register scoreboard of pending-write bits drives a decode stall. A sequential clear engine zeroes the array one entry per cycle on request, without asserting the global reset.

---
 rtl/regfile_sb_if.sv | 30 +++
 rtl/regfile_sb.sv | 106 ++++++++++
 tb/tb_regfile_sb.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Decode-stage register file bus: read ports, write-back, issue claim and clear control.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] outputA;
  logic [DATA_W-1:0] outputB;
  logic              wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] write_back_reg;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              busy_a;
  logic              busy_b;
  logic              stall;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output rs, rt, wr, wr_addr, write_back_reg, issue_en, issue_addr, clr_req,
    input  outputA, outputB, busy_a, busy_b, stall, clr_busy
  );

  modport slave (
    input  rs, rt, wr, wr_addr, write_back_reg, issue_en, issue_addr, clr_req,
    output outputA, outputB, busy_a, busy_b, stall, clr_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with pending-write scoreboard and sequential clear sweep.
// Optional write-through forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic          clock,
  input  logic          rst,
  regfile_sb_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DEPTH-1:0]    pend_q, pend_d;

  logic idle;
  logic wr_ok;
  logic issue_ok;
  logic fwd_a;
  logic fwd_b;

  assign idle     = (state_q == IDLE);
  assign wr_ok    = (ZERO_REG == 0) || (bus.wr_addr != '0);
  assign issue_ok = (ZERO_REG == 0) || (bus.issue_addr != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    pend_d  = pend_q;
    if (state_q == SWEEP) begin
      mem_d[cnt_q]  = '0;
      pend_d[cnt_q] = 1'b0;
      cnt_d         = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = IDLE;
      end
    end else begin
      if (bus.wr && wr_ok) begin
        mem_d[bus.wr_addr] = bus.write_back_reg;
      end
      if (bus.wr) begin
        pend_d[bus.wr_addr] = 1'b0;
      end
      // Set after clear: a same-cycle re-issue belongs to the newer producer.
      if (bus.issue_en && issue_ok) begin
        pend_d[bus.issue_addr] = 1'b1;
      end
      if (bus.clr_req) begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      mem_q   <= mem_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd_a = idle && bus.wr && (bus.wr_addr == bus.rs);
  assign fwd_b = idle && bus.wr && (bus.wr_addr == bus.rt);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  always_comb begin
    if ((ZERO_REG != 0) && (bus.rs == '0)) begin
      bus.outputA = '0;
    end else if (fwd_a) begin
      bus.outputA = bus.write_back_reg;
    end else begin
      bus.outputA = mem_q[bus.rs];
    end
    if ((ZERO_REG != 0) && (bus.rt == '0)) begin
      bus.outputB = '0;
    end else if (fwd_b) begin
      bus.outputB = bus.write_back_reg;
    end else begin
      bus.outputB = mem_q[bus.rt];
    end
    bus.busy_a   = pend_q[bus.rs] && !fwd_a;
    bus.busy_b   = pend_q[bus.rt] && !fwd_b;
    bus.clr_busy = !idle;
    bus.stall    = bus.busy_a || bus.busy_b || !idle;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb (DATA_W=32, ADDR_W=4, ZERO_REG=1).
module tb_regfile_sb;
  localparam int DEPTH = 16;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_pend [DEPTH];
  bit          m_sweep;
  int          m_idx;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  regfile_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = 32'h0;
      m_pend[i] = 1'b0;
    end
    m_sweep = 1'b0;
    m_idx   = 0;
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else if (m_sweep) begin
      m_mem[m_idx]  = 32'h0;
      m_pend[m_idx] = 1'b0;
      if (m_idx == DEPTH - 1) m_sweep = 1'b0;
      else m_idx = m_idx + 1;
    end else begin
      if (bus.wr && bus.wr_addr != 0) m_mem[bus.wr_addr] = bus.write_back_reg;
      if (bus.wr) m_pend[bus.wr_addr] = 1'b0;
      if (bus.issue_en && bus.issue_addr != 0) m_pend[bus.issue_addr] = 1'b1;
      if (bus.clr_req) begin
        m_sweep = 1'b1;
        m_idx   = 0;
      end
    end
  endtask

  task automatic model_check();
    bit fa, fb, ba, bb;
    logic [31:0] ea, eb;
    fa = BYP && !m_sweep && bus.wr && (bus.wr_addr == bus.rs);
    fb = BYP && !m_sweep && bus.wr && (bus.wr_addr == bus.rt);
    ea = (bus.rs == 0) ? 32'h0 : (fa ? bus.write_back_reg : m_mem[bus.rs]);
    eb = (bus.rt == 0) ? 32'h0 : (fb ? bus.write_back_reg : m_mem[bus.rt]);
    ba = m_pend[bus.rs] && !fa;
    bb = m_pend[bus.rt] && !fb;
    chk("outputA", bus.outputA, ea);
    chk("outputB", bus.outputB, eb);
    chk("busy_a", 32'(bus.busy_a), 32'(ba));
    chk("busy_b", 32'(bus.busy_b), 32'(bb));
    chk("stall", 32'(bus.stall), 32'(ba || bb || m_sweep));
    chk("clr_busy", 32'(bus.clr_busy), 32'(m_sweep));
  endtask

  task automatic cycle();
    @(negedge clock);
    model_check();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr = 1'b0; bus.issue_en = 1'b0; bus.clr_req = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    bus.wr = 1'b1; bus.wr_addr = a; bus.write_back_reg = d;
    cycle();
    bus.wr = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.rs = '0; bus.rt = '0; bus.wr_addr = '0; bus.write_back_reg = '0;
    bus.issue_addr = '0;
    idle_inputs();
    @(posedge clock);
    model_reset();
    #1;
    bus.rs = 4'd5; bus.rt = 4'd9;
    #1;
    chk("rst_outputA", bus.outputA, 32'h0);
    chk("rst_outputB", bus.outputB, 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_clr_busy", 32'(bus.clr_busy), 32'h0);
    cycle();
    rst = 1'b0;
    cycle();

    // write then read back
    do_write(4'd5, 32'hDEADBEEF);
    bus.rs = 4'd5;
    #1 chk("rd5", bus.outputA, 32'hDEADBEEF);
    cycle();
    // hardwired zero register
    do_write(4'd0, 32'hFFFF_FFFF);
    bus.rs = 4'd0;
    #1 chk("rd0", bus.outputA, 32'h0);
    cycle();

    // same-cycle write / read on port B
    bus.rt = 4'd9; bus.wr = 1'b1; bus.wr_addr = 4'd9; bus.write_back_reg = 32'h1234;
    #1 chk("fwd9", bus.outputB, BYP ? 32'h1234 : 32'h0);
    cycle();
    bus.wr = 1'b0;
    #1 chk("rd9", bus.outputB, 32'h1234);
    cycle();

    // scoreboard: issue then complete
    bus.issue_en = 1'b1; bus.issue_addr = 4'd3;
    cycle();
    bus.issue_en = 1'b0; bus.rs = 4'd3;
    #1 chk("busy3", 32'(bus.busy_a), 32'd1);
    chk("stall3", 32'(bus.stall), 32'd1);
    cycle();
    bus.wr = 1'b1; bus.wr_addr = 4'd3; bus.write_back_reg = 32'h33;
    #1 chk("busy3_wb", 32'(bus.busy_a), BYP ? 32'd0 : 32'd1);
    cycle();
    bus.wr = 1'b0;
    #1 chk("busy3_done", 32'(bus.busy_a), 32'd0);
    cycle();

    // issue and write-back to same register: set wins
    bus.issue_en = 1'b1; bus.issue_addr = 4'd7;
    bus.wr = 1'b1; bus.wr_addr = 4'd7; bus.write_back_reg = 32'h77;
    cycle();
    idle_inputs(); bus.rs = 4'd7;
    #1 chk("busy7", 32'(bus.busy_a), 32'd1);
    cycle();
    do_write(4'd7, 32'h78);

    // fill, sweep, drop a write mid-sweep
    for (int i = 0; i < DEPTH; i++) do_write(4'(i), $urandom);
    bus.clr_req = 1'b1;
    cycle();
    bus.clr_req = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus.clr_busy) break;
      n++;
      bus.wr = (k == 3); bus.wr_addr = 4'd2; bus.write_back_reg = 32'hAAAA5555;
      bus.issue_en = (k == 5); bus.issue_addr = 4'd4;
      cycle();
    end
    idle_inputs();
    chk("sweep_len", 32'(n), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      bus.rs = 4'(i); bus.rt = 4'(15 - i);
      #1 chk("swept", bus.outputA, 32'h0);
      cycle();
    end

    // reset in the middle of a sweep
    do_write(4'd6, 32'h66);
    do_write(4'd12, 32'hC0C0);
    bus.clr_req = 1'b1;
    cycle();
    bus.clr_req = 1'b0;
    repeat (6) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1 chk("rst_mid_sweep", 32'(bus.clr_busy), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      bus.rs = 4'(i);
      #1 chk("post_rst", bus.outputA, 32'h0);
      cycle();
    end
    do_write(4'd11, 32'hCAFEF00D);
    bus.rs = 4'd11;
    #1 chk("post_rst_wr", bus.outputA, 32'hCAFEF00D);
    cycle();

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      rst              = ($urandom_range(0, 199) == 0);
      bus.rs           = 4'($urandom);
      bus.rt           = 4'($urandom);
      bus.wr           = ($urandom_range(0, 1) == 1);
      bus.wr_addr      = 4'($urandom);
      bus.write_back_reg = $urandom;
      bus.issue_en     = ($urandom_range(0, 2) == 0);
      bus.issue_addr   = ($urandom_range(0, 3) == 0) ? bus.wr_addr : 4'($urandom);
      bus.clr_req      = ($urandom_range(0, 39) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
